dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data RAM between the core MEM stage (load/store unit) and a
//  secondary requester (DMA/program loader). Sequences every access as ISSUE + RESPONSE,
//  stalls the core while it does not own the RAM, and bounds secondary-port starvation.
//  Sits between the MEM stage and the data RAM; RAM has 1-cycle synchronous read latency.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width
//  MAX_WAIT  4   max consecutive core grants while d_req is pending (>=1)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous reset, active-high
//  c_req      in   1   core load/store request (held until c_stall low)
//  c_we       in   1   core write enable (1=store, 0=load)
//  c_wa       in   2   core size: 0 byte, 1 half, 2 word
//  c_addr     in   AW  core address
//  c_wdata    in   DW  core store data
//  c_rdata    out  DW  core load data (valid when c_req & !c_stall & !c_we)
//  c_stall    out  1   freeze MEM stage
//  d_req      in   1   secondary request (held until d_gnt)
//  d_we       in   1   secondary write enable
//  d_wa       in   2   secondary size, encoding as c_wa
//  d_addr     in   AW  secondary address
//  d_wdata    in   DW  secondary write data
//  d_gnt      out  1   1-cycle pulse: secondary request accepted this cycle
//  d_rvalid   out  1   1-cycle pulse: d_rdata valid (reads only)
//  d_rdata    out  DW  secondary read data
//  ram_addr   out  AW  to RAM
//  ram_wdata  out  DW  to RAM
//  ram_we     out  1   to RAM
//  ram_wa     out  2   to RAM
//  ram_rdata  in   DW  from RAM, valid one cycle after issue
// BEHAVIOUR
//  States: IDLE, C_RESP, D_RESP (2-bit register). wait_cnt: $clog2(MAX_WAIT+1) bits.
//  Reset (async): state=IDLE, wait_cnt=0; outputs then follow IDLE with no request:
//   ram_we=0, ram_addr=0, ram_wdata=0, ram_wa=0, d_gnt=0, d_rvalid=0, c_rdata=0, c_stall=0.
//  IDLE arbitration (combinational, one issue per cycle):
//   - pick_d = d_req & (!c_req | wait_cnt==MAX_WAIT); pick_c = c_req & !pick_d.
//   - pick_c: ram_* <= c_* this cycle; c_stall=1; next C_RESP.
//     If d_req: wait_cnt <= min(wait_cnt+1, MAX_WAIT).
//   - pick_d: ram_* <= d_* this cycle; d_gnt=1; c_stall=c_req; wait_cnt<=0; next D_RESP.
//   - neither: ram_we=0, outputs idle; wait_cnt<=0 if !d_req.
//  C_RESP: c_rdata=ram_rdata; c_stall=0 (core advances); ram_we=0; next IDLE.
//  D_RESP: d_rvalid=1 iff issued access was a read (registered flag); d_rdata=ram_rdata;
//   c_stall=c_req; ram_we=0; next IDLE.
//  Outside C_RESP c_rdata=0; outside D_RESP d_rdata=0.
//  Latency: core access = 2 cycles (1 stall cycle); core waits +2 cycles per DMA access.
//  Stores commit at the issue-cycle clock edge; ram_we never high outside an issue cycle.
//  No merging, no alignment checks: addr/size passed through unchanged.
//  Simultaneous c_req & d_req: core wins until wait_cnt==MAX_WAIT, then secondary wins once.
//  Reset mid-access: state returns to IDLE immediately, ram_we drops asynchronously;
//   an in-flight response is dropped (no d_rvalid), and the requester re-issues.
//  c_req dropped in C_RESP (flush): response ignored, still returns to IDLE.
// TESTING
//  1 Core load only: c_req=1,c_we=0,addr=0x10, RAM[0x10]=0xDEADBEEF -> c_stall 1 cycle,
//    next cycle c_rdata=0xDEADBEEF, c_stall=0.
//  2 Core store sb: c_we=1,c_wa=0,addr=0x21,wdata=0xAB -> ram_we=1,ram_wa=0 for exactly
//    one cycle; a subsequent load of 0x21 returns 0xAB in byte lane.
//  3 Secondary alone: d_req read addr 0x40 -> d_gnt pulse in cycle 0, d_rvalid with
//    RAM[0x40] in cycle 1; d_req write -> d_gnt, no d_rvalid.
//  4 Contention: c_req and d_req held high continuously, MAX_WAIT=4 -> 4 core accesses,
//    then 1 secondary grant, pattern repeats; wait_cnt never exceeds 4.
//  5 Reset asserted during ISSUE of a store -> ram_we falls without clock edge, state IDLE,
//    no d_rvalid/c_rdata glitch after release; all outputs at reset values.
//  6 Core flush: c_req dropped in C_RESP -> arbiter IDLE next cycle, next d_req granted.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus: core port, secondary (DMA/loader) port and RAM port.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          c_req;
    logic          c_we;
    logic [1:0]    c_wa;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic [DW-1:0] c_rdata;
    logic          c_stall;

    logic          d_req;
    logic          d_we;
    logic [1:0]    d_wa;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [1:0]    ram_wa;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  c_req, c_we, c_wa, c_addr, c_wdata,
        output c_rdata, c_stall,
        input  d_req, d_we, d_wa, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_addr, ram_wdata, ram_we, ram_wa,
        input  ram_rdata
    );

    modport master (
        output c_req, c_we, c_wa, c_addr, c_wdata,
        input  c_rdata, c_stall,
        output d_req, d_we, d_wa, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_addr, ram_wdata, ram_we, ram_wa,
        output ram_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the core MEM stage and a secondary
// requester; each access is ISSUE + RESPONSE, secondary starvation is bounded.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        C_RESP = 2'd1,
        D_RESP = 2'd2
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          d_rd;
    logic          pick_d;
    logic          pick_c;

    // Arbitration and all bus outputs; forced idle while reset is held so a
    // store in its issue cycle drops ram_we without waiting for a clock edge.
    always_comb begin
        pick_d        = bus.d_req & (~bus.c_req | (wait_cnt == WMAX));
        pick_c        = bus.c_req & ~pick_d;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wa    = 2'd0;
        bus.c_rdata   = '0;
        bus.c_stall   = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (pick_c) begin
                        bus.ram_addr  = bus.c_addr;
                        bus.ram_wdata = bus.c_wdata;
                        bus.ram_we    = bus.c_we;
                        bus.ram_wa    = bus.c_wa;
                        bus.c_stall   = 1'b1;
                    end else if (pick_d) begin
                        bus.ram_addr  = bus.d_addr;
                        bus.ram_wdata = bus.d_wdata;
                        bus.ram_we    = bus.d_we;
                        bus.ram_wa    = bus.d_wa;
                        bus.d_gnt     = 1'b1;
                        bus.c_stall   = bus.c_req;
                    end
                end
                C_RESP: begin
                    bus.c_rdata = bus.ram_rdata;
                end
                D_RESP: begin
                    bus.d_rvalid = d_rd;
                    bus.d_rdata  = bus.ram_rdata;
                    bus.c_stall  = bus.c_req;
                end
                default: ;
            endcase
        end
    end

    // Sequencer: one issue per IDLE cycle, always back to IDLE after the response;
    // wait_cnt counts core wins while the secondary port is waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            d_rd     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_c) begin
                        state <= C_RESP;
                        if (bus.d_req && wait_cnt != WMAX)
                            wait_cnt <= wait_cnt + WW'(1);
                    end else if (pick_d) begin
                        state    <= D_RESP;
                        wait_cnt <= '0;
                        d_rd     <= ~bus.d_we;
                    end else if (!bus.d_req) begin
                        wait_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed RAM model
// (sync write, 1-cycle read latency, word read at aligned address).
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] mem [0:255];

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM model
    always @(posedge clk) begin
        logic [7:0] a;
        logic [7:0] b;
        a = bus.ram_addr[7:0];
        b = {a[7:2], 2'b00};
        bus.ram_rdata <= {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
        if (bus.ram_we) begin
            mem[a] <= bus.ram_wdata[7:0];
            if (bus.ram_wa != 2'd0) mem[a + 8'd1] <= bus.ram_wdata[15:8];
            if (bus.ram_wa == 2'd2) begin
                mem[a + 8'd2] <= bus.ram_wdata[23:16];
                mem[a + 8'd3] <= bus.ram_wdata[31:24];
            end
        end
    end

    task automatic idle_inputs();
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_wa = 2'd2;
        bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wa = 2'd2;
        bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ram_wa} !== 67'd0) begin
            failures++;
            $display("FAIL reset_ram got we=%b addr=%h wd=%h wa=%0d exp 0",
                     bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ram_wa);
        end
        checks++;
        if ({bus.d_gnt, bus.d_rvalid, bus.c_stall, bus.c_rdata, bus.d_rdata} !== 67'd0) begin
            failures++;
            $display("FAIL reset_ctl got gnt=%b rv=%b stall=%b crd=%h drd=%h exp 0",
                     bus.d_gnt, bus.d_rvalid, bus.c_stall, bus.c_rdata, bus.d_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_core_load();
        @(negedge clk);
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_wa = 2'd2; bus.c_addr = 32'h10;
        #1;
        checks++;
        if (bus.c_stall !== 1'b1 || bus.ram_addr !== 32'h10 || bus.ram_we !== 1'b0) begin
            failures++;
            $display("FAIL load_issue got stall=%b addr=%h we=%b exp 1/10/0",
                     bus.c_stall, bus.ram_addr, bus.ram_we);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.c_stall !== 1'b0 || bus.c_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL load_resp got stall=%b rdata=%h exp 0/deadbeef",
                     bus.c_stall, bus.c_rdata);
        end
        bus.c_req = 1'b0;
    endtask

    task automatic test_core_store();
        @(negedge clk);
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_wa = 2'd0;
        bus.c_addr = 32'h21; bus.c_wdata = 32'hAB;
        #1;
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_wa !== 2'd0 ||
            bus.ram_wdata !== 32'hAB || bus.c_stall !== 1'b1) begin
            failures++;
            $display("FAIL sb_issue got we=%b wa=%0d wd=%h stall=%b exp 1/0/ab/1",
                     bus.ram_we, bus.ram_wa, bus.ram_wdata, bus.c_stall);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.ram_we !== 1'b0 || bus.c_stall !== 1'b0) begin
            failures++;
            $display("FAIL sb_resp got we=%b stall=%b exp 0/0", bus.ram_we, bus.c_stall);
        end
        bus.c_req = 1'b0;
        @(negedge clk);
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_wa = 2'd2; bus.c_addr = 32'h21;
        @(negedge clk); #1;
        checks++;
        if (bus.c_rdata !== 32'h0000AB00) begin
            failures++;
            $display("FAIL sb_readback got %h exp 0000ab00", bus.c_rdata);
        end
        bus.c_req = 1'b0;
    endtask

    task automatic test_secondary();
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_wa = 2'd2; bus.d_addr = 32'h40;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.c_stall !== 1'b0 || bus.ram_addr !== 32'h40) begin
            failures++;
            $display("FAIL d_rd_issue got gnt=%b stall=%b addr=%h exp 1/0/40",
                     bus.d_gnt, bus.c_stall, bus.ram_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.d_gnt !== 1'b0 || bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL d_rd_resp got gnt=%b rv=%b rdata=%h exp 0/1/12345678",
                     bus.d_gnt, bus.d_rvalid, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h44; bus.d_wdata = 32'hCAFEF00D;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_wdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL d_wr_issue got gnt=%b we=%b wd=%h exp 1/1/cafef00d",
                     bus.d_gnt, bus.ram_we, bus.ram_wdata);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.d_rvalid !== 1'b0 || bus.d_gnt !== 1'b0 || bus.ram_we !== 1'b0) begin
            failures++;
            $display("FAIL d_wr_resp got rv=%b gnt=%b we=%b exp 0/0/0",
                     bus.d_rvalid, bus.d_gnt, bus.ram_we);
        end
        bus.d_req = 1'b0;
        checks++;
        if ({mem[8'h47], mem[8'h46], mem[8'h45], mem[8'h44]} !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL d_wr_mem got %h exp cafef00d",
                     {mem[8'h47], mem[8'h46], mem[8'h45], mem[8'h44]});
        end
    endtask

    task automatic test_contention();
        logic [19:0] gnt_seen, gnt_exp;
        logic [19:0] cres_seen, cres_exp;
        logic [19:0] rv_seen, rv_exp;
        for (int i = 0; i < 20; i++) begin
            gnt_exp[i]  = (i % 10 == 8);
            rv_exp[i]   = (i % 10 == 9);
            cres_exp[i] = (i % 10 < 8) && (i % 2 == 1);
        end
        @(negedge clk);
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        for (int i = 0; i < 20; i++) begin
            #1;
            gnt_seen[i]  = bus.d_gnt;
            rv_seen[i]   = bus.d_rvalid;
            cres_seen[i] = ~bus.c_stall;
            @(negedge clk);
        end
        bus.c_req = 1'b0; bus.d_req = 1'b0;
        checks++;
        if (gnt_seen !== gnt_exp) begin
            failures++;
            $display("FAIL cont_gnt got %b exp %b", gnt_seen, gnt_exp);
        end
        checks++;
        if (cres_seen !== cres_exp) begin
            failures++;
            $display("FAIL cont_core got %b exp %b", cres_seen, cres_exp);
        end
        checks++;
        if (rv_seen !== rv_exp) begin
            failures++;
            $display("FAIL cont_rvalid got %b exp %b", rv_seen, rv_exp);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_wa = 2'd0;
        bus.c_addr = 32'h30; bus.c_wdata = 32'h55;
        #1;
        checks++;
        if (bus.ram_we !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_we got %b exp 1", bus.ram_we);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h0 || bus.c_stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_async got we=%b addr=%h stall=%b exp 0/0/0",
                     bus.ram_we, bus.ram_addr, bus.c_stall);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if (mem[8'h30] !== 8'h00) begin
            failures++;
            $display("FAIL rst_no_commit got %h exp 00", mem[8'h30]);
        end
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        @(negedge clk);
        bus.d_req = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_drop_resp got rv=%b rdata=%h exp 0/0",
                     bus.d_rvalid, bus.d_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.d_rvalid !== 1'b0 || bus.c_rdata !== 32'h0 || bus.d_gnt !== 1'b0) begin
            failures++;
            $display("FAIL rst_release got rv=%b crd=%h gnt=%b exp 0/0/0",
                     bus.d_rvalid, bus.c_rdata, bus.d_gnt);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h10;
        @(negedge clk);
        bus.c_req = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        #1;
        checks++;
        if (bus.c_stall !== 1'b0 || bus.d_gnt !== 1'b0) begin
            failures++;
            $display("FAIL flush_resp got stall=%b gnt=%b exp 0/0", bus.c_stall, bus.d_gnt);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL flush_gnt got %b exp 1", bus.d_gnt);
        end
        @(negedge clk); #1;
        bus.d_req = 1'b0;
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL flush_rvalid got rv=%b rdata=%h exp 1/12345678",
                     bus.d_rvalid, bus.d_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'hDEADBEEF;
        {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} = 32'h12345678;
        test_reset();
        test_core_load();
        test_core_store();
        test_secondary();
        test_contention();
        test_reset_mid();
        test_flush();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
